// File: rtl/avmm_arb_pkg.sv
// ============================================================================
// Module      : avmm_arb_pkg
// Description : Shared types, width helpers and defaults for the AVMM write arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package avmm_arb_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUS  = 1'b1
    } arb_state_t;

    // Index width; a single requester still needs one bit.
    function automatic int calc_gw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Watchdog counter width, able to hold TIMEOUT_CYCLES-1.
    function automatic int calc_cnt_w(input int t);
        return (t > 1) ? $clog2(t) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/avmm_rr_pick.sv
// ============================================================================
// Module      : avmm_rr_pick
// Description : Combinational rotate-priority encoder; the search starts just after last_grant.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avmm_rr_pick
    import avmm_arb_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0]              req,
    input  logic [calc_gw(NUM_REQ)-1:0]     last_grant,
    output logic [calc_gw(NUM_REQ)-1:0]     winner,
    output logic                            valid
);

    localparam int GW = calc_gw(NUM_REQ);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [2*NUM_REQ-1:0] req_rot;
    int                   shamt;
    int                   offset;

    // Position j of req_rot is requester (last_grant+1+j) mod NUM_REQ.
    always_comb begin
        req_dbl = {req, req};
        shamt   = int'(last_grant) + 1;
        req_rot = req_dbl >> shamt;
        offset  = 0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                offset = j;
            end
        end
        winner = GW'((int'(last_grant) + 1 + offset) % NUM_REQ);
        valid  = |req;
    end

endmodule

`default_nettype wire

// File: rtl/avmm_write_arbiter.sv
// ============================================================================
// Module      : avmm_write_arbiter
// Description : Round-robin arbiter sharing one Avalon-MM write port among
//               NUM_REQ write-only masters, with a hung-slave watchdog.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avmm_write_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                            sysclk,
    input  logic                            sysreset,
    input  logic [NUM_REQ*ADDR_W-1:0]       req_address,
    input  logic [NUM_REQ*DATA_W-1:0]       req_writedata,
    input  logic [NUM_REQ-1:0]              req_write,
    output logic [NUM_REQ-1:0]              req_waitrequest,
    output logic [ADDR_W-1:0]               av_address,
    output logic [DATA_W-1:0]               av_writedata,
    output logic                            av_write,
    input  logic                            av_waitrequest,
    output logic [calc_gw(NUM_REQ)-1:0]     grant_id,
    output logic                            busy,
    output logic                            timeout_err,
    input  logic                            clear_err
);

    localparam int              GW             = calc_gw(NUM_REQ);
    localparam int              CNT_W          = calc_cnt_w(TIMEOUT_CYCLES);
    localparam bit              WD_EN          = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] WD_LAST       = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [GW-1:0]   LAST_GRANT_RST = GW'(NUM_REQ - 1);

    arb_state_t         state_q, state_d;
    logic [GW-1:0]      last_grant_q, last_grant_d;
    logic [GW-1:0]      grant_id_q, grant_id_d;
    logic [ADDR_W-1:0]  av_address_q, av_address_d;
    logic [DATA_W-1:0]  av_writedata_q, av_writedata_d;
    logic               av_write_q, av_write_d;
    logic               timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;

    logic [GW-1:0]      pick_id;
    logic               pick_valid;
    logic [ADDR_W-1:0]  sel_address;
    logic [DATA_W-1:0]  sel_writedata;
    logic               wd_expire;

    avmm_rr_pick #(
        .NUM_REQ    (NUM_REQ)
    ) u_pick (
        .req        (req_write),
        .last_grant (last_grant_q),
        .winner     (pick_id),
        .valid      (pick_valid)
    );

    always_comb begin
        sel_address   = '0;
        sel_writedata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == GW'(i)) begin
                sel_address   = req_address[i*ADDR_W +: ADDR_W];
                sel_writedata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign wd_expire = WD_EN && (state_q == ST_BUS) && av_waitrequest && (wd_cnt_q == WD_LAST);

    // State register
    always_ff @(posedge sysclk or posedge sysreset) begin
        if (sysreset) begin
            state_q        <= ST_IDLE;
            last_grant_q   <= LAST_GRANT_RST;
            grant_id_q     <= '0;
            av_address_q   <= '0;
            av_writedata_q <= '0;
            av_write_q     <= 1'b0;
            timeout_err_q  <= 1'b0;
            wd_cnt_q       <= '0;
        end else begin
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            grant_id_q     <= grant_id_d;
            av_address_q   <= av_address_d;
            av_writedata_q <= av_writedata_d;
            av_write_q     <= av_write_d;
            timeout_err_q  <= timeout_err_d;
            wd_cnt_q       <= wd_cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        grant_id_d     = grant_id_q;
        av_address_d   = av_address_q;
        av_writedata_d = av_writedata_q;
        av_write_d     = av_write_q;
        wd_cnt_d       = wd_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d        = ST_BUS;
                    av_address_d   = sel_address;
                    av_writedata_d = sel_writedata;
                    av_write_d     = 1'b1;
                    grant_id_d     = pick_id;
                    last_grant_d   = pick_id;
                    wd_cnt_d       = '0;
                end
            end
            ST_BUS: begin
                if (!av_waitrequest || wd_expire) begin
                    state_d    = ST_IDLE;
                    av_write_d = 1'b0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                av_write_d = 1'b0;
            end
        endcase
        // An abort in the same cycle as clear_err leaves the flag set.
        timeout_err_d = timeout_err_q;
        if (wd_expire) begin
            timeout_err_d = 1'b1;
        end else if (clear_err) begin
            timeout_err_d = 1'b0;
        end
    end

    // Output logic
    always_comb begin
        busy            = (state_q == ST_BUS);
        req_waitrequest = '1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (busy && (grant_id_q == GW'(i)) && (!av_waitrequest || wd_expire)) begin
                req_waitrequest[i] = 1'b0;
            end
        end
    end

    assign av_address   = av_address_q;
    assign av_writedata = av_writedata_q;
    assign av_write     = av_write_q;
    assign grant_id     = grant_id_q;
    assign timeout_err  = timeout_err_q;

endmodule

`default_nettype wire
